// File: rtl/ld3320_bus_arbiter.sv
// Purpose : round-robin arbiter sharing one LD3320 register read/write engine among three requesters.
// Latency : req seen in IDLE -> eng_ena next cycle -> ack one cycle after eng_done (or after TIMEOUT wait cycles).
// Backpress: requesters hold req/command until ack; no new grant while a transaction is in flight.
module ld3320_bus_arbiter #(
  parameter logic [15:0] TIMEOUT = 16'd2000
) (
  input  logic        clk,
  input  logic        sys_rstn,
  input  logic [2:0]  req,
  input  logic [2:0]  req_sel,
  input  logic [23:0] req_addr,
  input  logic [23:0] req_wdata,
  output logic [2:0]  ack,
  output logic        err,
  output logic [7:0]  rdata,
  output logic        busy,
  output logic        eng_ena,
  output logic        eng_sel,
  output logic [7:0]  eng_address,
  output logic [7:0]  eng_data,
  input  logic        eng_done,
  input  logic [7:0]  eng_rdata
);

  // Last counter value allowed in WAIT; reaching it without eng_done aborts.
  localparam logic [15:0] TMO_LAST = TIMEOUT - 16'd1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  grant_q, grant_d;
  logic [1:0]  last_grant_q, last_grant_d;
  logic [15:0] cnt_q, cnt_d;
  logic        err_flag_q, err_flag_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        eng_sel_q, eng_sel_d;
  logic [7:0]  eng_addr_q, eng_addr_d;
  logic [7:0]  eng_data_q, eng_data_d;

  logic [1:0]  pick_idx;
  logic [4:0]  pick_base;

  // Round-robin pick: search starts one past the last requester served.
  always_comb begin
    pick_idx = 2'd0;
    unique case (last_grant_q)
      2'd0: begin
        if (req[1])      pick_idx = 2'd1;
        else if (req[2]) pick_idx = 2'd2;
        else             pick_idx = 2'd0;
      end
      2'd1: begin
        if (req[2])      pick_idx = 2'd2;
        else if (req[0]) pick_idx = 2'd0;
        else             pick_idx = 2'd1;
      end
      default: begin
        if (req[0])      pick_idx = 2'd0;
        else if (req[1]) pick_idx = 2'd1;
        else             pick_idx = 2'd2;
      end
    endcase
  end

  // Byte lane of the picked requester inside the packed address/data buses.
  assign pick_base = {pick_idx, 3'b000};

  // Next-state and datapath updates for the arbitration FSM.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    err_flag_d   = err_flag_q;
    rdata_d      = rdata_q;
    eng_sel_d    = eng_sel_q;
    eng_addr_d   = eng_addr_q;
    eng_data_d   = eng_data_q;

    unique case (state_q)
      S_IDLE: begin
        if (|req) begin
          grant_d    = pick_idx;
          eng_sel_d  = req_sel[pick_idx];
          eng_addr_d = req_addr[pick_base +: 8];
          eng_data_d = req_wdata[pick_base +: 8];
          state_d    = S_ISSUE;
        end
      end

      S_ISSUE: begin
        cnt_d   = 16'd0;
        state_d = S_WAIT;
      end

      S_WAIT: begin
        // A completion in the final timeout cycle still counts as success.
        if (eng_done) begin
          rdata_d    = eng_sel_q ? 8'h00 : eng_rdata;
          err_flag_d = 1'b0;
          state_d    = S_RESP;
        end else if (cnt_q >= TMO_LAST) begin
          rdata_d    = 8'h00;
          err_flag_d = 1'b1;
          state_d    = S_RESP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      S_RESP: begin
        last_grant_d = grant_q;
        err_flag_d   = 1'b0;
        state_d      = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset leaves requester 0 first in line.
  always_ff @(posedge clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      state_q      <= S_IDLE;
      grant_q      <= 2'd0;
      last_grant_q <= 2'd2;
      cnt_q        <= 16'd0;
      err_flag_q   <= 1'b0;
      rdata_q      <= 8'h00;
      eng_sel_q    <= 1'b0;
      eng_addr_q   <= 8'h00;
      eng_data_q   <= 8'h00;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      err_flag_q   <= err_flag_d;
      rdata_q      <= rdata_d;
      eng_sel_q    <= eng_sel_d;
      eng_addr_q   <= eng_addr_d;
      eng_data_q   <= eng_data_d;
    end
  end

  // Moore-decoded outputs; the command fields come straight from registers.
  always_comb begin
    ack         = (state_q == S_RESP) ? (3'b001 << grant_q) : 3'b000;
    err         = (state_q == S_RESP) && err_flag_q;
    rdata       = rdata_q;
    busy        = (state_q != S_IDLE);
    eng_ena     = (state_q == S_ISSUE);
    eng_sel     = eng_sel_q;
    eng_address = eng_addr_q;
    eng_data    = eng_data_q;
  end

endmodule
